// File: rtl/core_pkg.sv
// Shared types and helpers for the vector-instruction broadcast controller.
package core_pkg;

    // Controller states: normal operation, drain before flush, one-cycle clear.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } bcast_state_e;

    localparam int unsigned StallCntWidth = 16;

    // Bits needed to hold a count from 0 up to and including depth.
    function automatic int unsigned GetWidth(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vinsn_bcast_ctrl_if.sv
// Signal bundle between the broadcast controller, the dispatcher, the
// functional-unit consumers and the shared multi-read-port FIFO.
//
// Handshake rule for every valid/ready pair in this bundle: a transfer
// happens in a cycle where valid and ready are both 1; valid never depends
// combinationally on the ready of the same channel.
interface vinsn_bcast_ctrl_if #(
    parameter int unsigned NrConsumer = 2,
    parameter int unsigned DataWidth  = 32
);
    import core_pkg::*;

    logic                                   in_valid_i;
    logic                                   in_ready_o;
    logic [DataWidth-1:0]                   in_data_i;
    logic [NrConsumer-1:0]                  out_valid_o;
    logic [NrConsumer-1:0]                  out_ready_i;
    logic [NrConsumer-1:0][DataWidth-1:0]   out_data_o;
    logic                                   flush_req_i;
    logic                                   flush_kill_i;
    logic                                   flush_ack_o;
    logic                                   fifo_full_i;
    logic [NrConsumer-1:0]                  fifo_empty_i;
    logic [NrConsumer-1:0][DataWidth-1:0]   fifo_data_i;
    logic                                   fifo_push_o;
    logic [DataWidth-1:0]                   fifo_data_o;
    logic [NrConsumer-1:0]                  fifo_pop_o;
    logic                                   fifo_flush_o;
    logic [NrConsumer-1:0][StallCntWidth-1:0] stall_cnt_o;

    // Controller view.
    modport master (
        input  in_valid_i, in_data_i, out_ready_i, flush_req_i, flush_kill_i,
               fifo_full_i, fifo_empty_i, fifo_data_i,
        output in_ready_o, out_valid_o, out_data_o, flush_ack_o,
               fifo_push_o, fifo_data_o, fifo_pop_o, fifo_flush_o, stall_cnt_o
    );

    // Environment view (dispatcher, consumers, FIFO).
    modport slave (
        output in_valid_i, in_data_i, out_ready_i, flush_req_i, flush_kill_i,
               fifo_full_i, fifo_empty_i, fifo_data_i,
        input  in_ready_o, out_valid_o, out_data_o, flush_ack_o,
               fifo_push_o, fifo_data_o, fifo_pop_o, fifo_flush_o, stall_cnt_o
    );

endinterface

// File: rtl/bcast_lead_cnt.sv
// Up/down counter of entries consumer i-1 has popped that consumer i has not.
module bcast_lead_cnt
    import core_pkg::*;
#(
    parameter int unsigned Depth = 8,
    localparam int unsigned Width = GetWidth(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q;

    // Count up on upstream pops, down on own pops; both together cancel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !dec_i) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt_o = cnt_q;

    // A lead beyond the FIFO depth (or a wrap below zero) means the ordering broke.
    a_lead_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= Width'(Depth));

endmodule

// File: rtl/vinsn_bcast_ctrl.sv
// Broadcast-queue controller: dispatcher push path, per-consumer read
// streams with in-order gating, and drain/kill flush sequencing.
// Optional feature macro: VINSN_BCAST_STALL_CNT_EN (per-consumer stall counters).
module vinsn_bcast_ctrl
    import core_pkg::*;
#(
    parameter int unsigned NrConsumer = 2,
    parameter int unsigned Depth      = 8,
    localparam int unsigned LeadWidth = GetWidth(Depth)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    vinsn_bcast_ctrl_if.master                  bus,
    output bcast_state_e                        dbg_state,
    output logic [NrConsumer-1:0][LeadWidth-1:0] dbg_lead
);

    bcast_state_e          state_q, state_d;
    logic                  is_clear;
    logic                  in_ready;
    logic [NrConsumer-1:0] lead_ok;
    logic [NrConsumer-1:0] out_valid;
    logic [NrConsumer-1:0] pop;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: kill clears at once, drain waits for the slowest consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (bus.flush_req_i) begin
                    state_d = bus.flush_kill_i ? CLEAR : DRAIN;
                end
            end
            DRAIN: begin
                if (bus.fifo_empty_i[NrConsumer-1] || bus.flush_kill_i) begin
                    state_d = CLEAR;
                end
            end
            CLEAR:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign is_clear  = (state_q == CLEAR);
    assign dbg_state = state_q;

    // Push path.
    assign in_ready        = (state_q == RUN) && !bus.fifo_full_i;
    assign bus.in_ready_o  = in_ready;
    assign bus.fifo_push_o = bus.in_valid_i && in_ready;
    assign bus.fifo_data_o = bus.in_data_i;

    // Consumer 0 is never gated; consumer i waits for a registered lead.
    assign lead_ok[0]  = 1'b1;
    assign dbg_lead[0] = '0;

    for (genvar i = 1; i < NrConsumer; i++) begin : g_lead
        logic [LeadWidth-1:0] cnt;

        bcast_lead_cnt #(
            .Depth (Depth)
        ) u_lead_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (is_clear),
            .inc_i  (pop[i-1]),
            .dec_i  (pop[i]),
            .cnt_o  (cnt)
        );

        assign lead_ok[i]  = (cnt != '0);
        assign dbg_lead[i] = cnt;
    end

    // Read streams.
    assign out_valid        = {NrConsumer{!is_clear}} & ~bus.fifo_empty_i & lead_ok;
    assign pop              = out_valid & bus.out_ready_i;
    assign bus.out_valid_o  = out_valid;
    assign bus.fifo_pop_o   = pop;
    assign bus.out_data_o   = bus.fifo_data_i;

    // Flush completion.
    assign bus.fifo_flush_o = is_clear;
    assign bus.flush_ack_o  = is_clear;

`ifdef VINSN_BCAST_STALL_CNT_EN
    logic [NrConsumer-1:0][StallCntWidth-1:0] stall_q;

    // Saturating per-consumer stall counters, cleared by a flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NrConsumer; i++) begin
                if (is_clear) begin
                    stall_q[i] <= '0;
                end else if (out_valid[i] && !bus.out_ready_i[i] && (stall_q[i] != '1)) begin
                    stall_q[i] <= stall_q[i] + 1'b1;
                end
            end
        end
    end

    assign bus.stall_cnt_o = stall_q;
`else
    assign bus.stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vinsn_bcast_ctrl.sv
// Self-checking bench for vinsn_bcast_ctrl with a behavioural FIFO and a
// queue-based reference model of what each consumer must receive and when.
module tb_vinsn_bcast_ctrl;
    import core_pkg::*;

    localparam int unsigned NR    = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned LW    = GetWidth(DEPTH);

    logic clk;
    logic rst_n;
    bcast_state_e              dbg_state;
    logic [NR-1:0][LW-1:0]     dbg_lead;

    vinsn_bcast_ctrl_if #(.NrConsumer(NR), .DataWidth(DW)) bus ();

    vinsn_bcast_ctrl #(.NrConsumer(NR), .Depth(DEPTH)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_lead  (dbg_lead)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting on DUT (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural FIFO ----------------
    logic [DW-1:0] mem [DEPTH];
    int unsigned   wp;
    int unsigned   rp [NR];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= 0;
            for (int i = 0; i < NR; i++) rp[i] <= 0;
        end else if (bus.fifo_flush_o) begin
            wp <= 0;
            for (int i = 0; i < NR; i++) rp[i] <= 0;
        end else begin
            if (bus.fifo_push_o && ((wp - rp[NR-1]) < DEPTH)) begin
                mem[wp % DEPTH] <= bus.fifo_data_o;
                wp <= wp + 1;
            end
            for (int i = 0; i < NR; i++) begin
                if (bus.fifo_pop_o[i] && (rp[i] != wp)) rp[i] <= rp[i] + 1;
            end
        end
    end

    always_comb begin
        bus.fifo_full_i = ((wp - rp[NR-1]) >= DEPTH);
        for (int i = 0; i < NR; i++) begin
            bus.fifo_empty_i[i] = (rp[i] == wp);
            bus.fifo_data_i[i]  = mem[rp[i] % DEPTH];
        end
    end

    // ---------------- scoreboard / reference model ----------------
    logic [DW-1:0] exp_q [NR][$];
    int            deliv [NR];
    int            stall_exp [NR];
    bit            busy = 1'b0;
    bit            ack_pend = 1'b0;

    initial begin
        for (int i = 0; i < NR; i++) begin
            deliv[i] = 0;
            stall_exp[i] = 0;
        end
    end

    // Monitor: predict every observable output from the model, then consume handshakes.
    always @(negedge clk) begin : mon
        logic          exp_ack;
        logic          exp_full;
        logic          exp_in_ready;
        logic          last_empty;
        logic [NR-1:0] exp_valid;
        if (!rst_n) begin
            busy = 1'b0;
            ack_pend = 1'b0;
            for (int i = 0; i < NR; i++) begin
                exp_q[i].delete();
                deliv[i] = 0;
                stall_exp[i] = 0;
            end
            check("rst_in_ready", bus.in_ready_o, 1'b1);
            check("rst_out_valid", bus.out_valid_o, '0);
            check("rst_ack", bus.flush_ack_o, 1'b0);
            check("rst_fifo_flush", bus.fifo_flush_o, 1'b0);
            check("rst_pop", bus.fifo_pop_o, '0);
            check("rst_stall", bus.stall_cnt_o, '0);
            check("rst_state", dbg_state, RUN);
            check("rst_lead1", dbg_lead[1], '0);
        end else begin
            exp_ack      = ack_pend;
            exp_full     = (exp_q[NR-1].size() == DEPTH);
            last_empty   = (exp_q[NR-1].size() == 0);
            exp_in_ready = !busy && !exp_ack && !exp_full;
            for (int i = 0; i < NR; i++) begin
                exp_valid[i] = !exp_ack && (exp_q[i].size() != 0) &&
                               ((i == 0) || (deliv[i-1] > deliv[i]));
            end
            check("in_ready", bus.in_ready_o, exp_in_ready);
            check("fifo_push", bus.fifo_push_o, bus.in_valid_i && exp_in_ready);
            check("flush_ack", bus.flush_ack_o, exp_ack);
            check("fifo_flush", bus.fifo_flush_o, exp_ack);
            check("out_valid", bus.out_valid_o, exp_valid);
            check("fifo_pop", bus.fifo_pop_o, exp_valid & bus.out_ready_i);
            for (int i = 1; i < NR; i++) begin
                check("lead", 64'(dbg_lead[i]), 64'(deliv[i-1] - deliv[i]));
            end
            for (int i = 0; i < NR; i++) begin
`ifdef VINSN_BCAST_STALL_CNT_EN
                check("stall_cnt", bus.stall_cnt_o[i], 64'(stall_exp[i]));
`else
                check("stall_cnt", bus.stall_cnt_o[i], '0);
`endif
            end

            // Consume handshakes seen at the DUT boundary.
            for (int i = 0; i < NR; i++) begin
                if (bus.out_valid_o[i] && bus.out_ready_i[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check("out_underflow", bus.out_data_o[i], 'x);
                    end else begin
                        check("out_data", bus.out_data_o[i], exp_q[i].pop_front());
                    end
                    deliv[i]++;
                end
                if (exp_ack) stall_exp[i] = 0;
                else if (exp_valid[i] && !bus.out_ready_i[i] && stall_exp[i] < 65535) stall_exp[i]++;
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                for (int i = 0; i < NR; i++) exp_q[i].push_back(bus.in_data_i);
            end

            // Flush timeline.
            if (exp_ack) begin
                ack_pend = 1'b0;
                busy = 1'b0;
                for (int i = 0; i < NR; i++) begin
                    exp_q[i].delete();
                    deliv[i] = 0;
                end
            end else if (!busy) begin
                if (bus.flush_req_i) begin
                    if (bus.flush_kill_i) ack_pend = 1'b1;
                    else busy = 1'b1;
                end
            end else if (last_empty || bus.flush_kill_i) begin
                ack_pend = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one();
        bit done = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = $urandom;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            done = bus.in_ready_o;
            step();
        end
        bus.in_valid_i = 1'b0;
        if (!done) timeout("push_one");
    endtask

    task automatic flush(input bit kill, input int esc, input bit rnd, output int lat);
        bit got = 1'b0;
        lat = -1;
        bus.in_valid_i   = 1'b0;
        bus.flush_req_i  = 1'b1;
        bus.flush_kill_i = kill;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (bus.flush_ack_o) begin
                got = 1'b1;
                lat = k;
            end
            step();
            if (k == esc) bus.flush_kill_i = 1'b1;
            if (rnd) bus.out_ready_i = NR'($urandom_range(0, 3));
        end
        bus.flush_req_i  = 1'b0;
        bus.flush_kill_i = 1'b0;
        if (!got) timeout("flush_ack");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int d1;
        rst_n            = 1'b0;
        bus.in_valid_i   = 1'b0;
        bus.in_data_i    = '0;
        bus.out_ready_i  = '0;
        bus.flush_req_i  = 1'b0;
        bus.flush_kill_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Fill to depth, then a ninth request must be refused; then drain.
        for (int n = 0; n < DEPTH; n++) push_one();
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        check("ninth_in_ready", bus.in_ready_o, 1'b0);
        step();
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 2'b11;
        repeat (30) step();

        // Consumer 0 stalled: consumer 1 must wait, then take exactly one.
        bus.out_ready_i = 2'b10;
        for (int n = 0; n < 3; n++) push_one();
        repeat (3) step();
        @(negedge clk);
        check("c1_blocked", bus.out_valid_o[1], 1'b0);
        step();
        d1 = deliv[1];
        bus.out_ready_i = 2'b11;
        step();
        bus.out_ready_i = 2'b10;
        repeat (5) step();
        check("c1_one_entry", 64'(deliv[1] - d1), 64'd1);
        bus.out_ready_i = 2'b11;
        repeat (10) step();

        // Drain flush after consumer 0 has taken everything.
        bus.out_ready_i = 2'b00;
        for (int n = 0; n < 4; n++) push_one();
        bus.out_ready_i = 2'b01;
        repeat (6) step();
        bus.out_ready_i = 2'b11;
        flush(1'b0, -1, 1'b0, lat);

        // Kill flush with 5 entries queued.
        bus.out_ready_i = 2'b00;
        for (int n = 0; n < 5; n++) push_one();
        flush(1'b1, -1, 1'b0, lat);
        check("kill_latency", 64'(lat), 64'd1);
        @(negedge clk);
        check("kill_lead_zero", dbg_lead[1], '0);
        step();

        // Drain escalated to kill.
        for (int n = 0; n < 4; n++) push_one();
        bus.out_ready_i = 2'b01;
        repeat (6) step();
        bus.out_ready_i = 2'b00;
        flush(1'b0, 3, 1'b0, lat);

        // Reset during drain.
        for (int n = 0; n < 3; n++) push_one();
        bus.flush_req_i = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        bus.flush_req_i = 1'b0;
        rst_n = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready_o, 1'b1);
        check("post_rst_state", dbg_state, RUN);
        step();

`ifdef VINSN_BCAST_STALL_CNT_EN
        // Twenty stalled cycles on consumer 0, then cleared by a kill.
        bus.out_ready_i = 2'b00;
        push_one();
        repeat (20) step();
        @(negedge clk);
        check("stall20", bus.stall_cnt_o[0], 64'd20);
        step();
        flush(1'b1, -1, 1'b0, lat);
        @(negedge clk);
        check("stall_cleared", bus.stall_cnt_o[0], '0);
        step();
`endif

        // Random traffic with random flushes.
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 60; c++) begin
                bus.in_valid_i  = 1'($urandom_range(0, 1));
                bus.in_data_i   = $urandom;
                bus.out_ready_i = NR'($urandom_range(0, 3));
                step();
            end
            bus.in_valid_i = 1'b0;
            flush(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 2 : -1, 1'b1, lat);
        end
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

endmodule
